// File: rtl/wrf_rx_sink_pkg.sv
// wrf_sink_pkg: fabric address map, status bit index and the stream word carried through the sink FIFO.
package wrf_sink_pkg;

    localparam logic [1:0] c_WRF_DATA   = 2'd0;
    localparam logic [1:0] c_WRF_OOB    = 2'd1;
    localparam logic [1:0] c_WRF_STATUS = 2'd2;
    localparam logic [1:0] c_WRF_USER   = 2'd3;

    localparam int c_WRF_STATUS_ERR = 1;

    typedef struct packed {
        logic [15:0] dat;
        logic        sop;
        logic        eop;
        logic        bytesel;
        logic        err;
        logic        oob;
    } t_wrf_word;

    typedef enum logic {IDLE, FRAME} t_sink_state;

endpackage

// File: rtl/wrf_rx_sink_if.sv
// wrf_rx_sink_if: pipelined Wishbone fabric bus between a WR fabric source (master) and the sink (slave).
interface wrf_rx_sink_if;

    logic        cyc;
    logic        stb;
    logic        we;
    logic [1:0]  adr;
    logic [15:0] dat;
    logic [1:0]  sel;
    logic        stall;
    logic        ack;
    logic        err;

    modport master (output cyc, stb, we, adr, dat, sel, input stall, ack, err);
    modport slave  (input cyc, stb, we, adr, dat, sel, output stall, ack, err);

endinterface

// File: rtl/wrf_rx_sink_fifo.sv
// wrf_sink_fifo: synchronous FIFO of stream words with occupancy count; head word reads as zero when empty.
module wrf_sink_fifo
    import wrf_sink_pkg::*;
#(
    parameter int g_depth = 64
) (
    input  logic                     clk_sys,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  t_wrf_word                din,
    output t_wrf_word                dout,
    output logic                     empty,
    output logic [$clog2(g_depth):0] count
);

    localparam int AW = $clog2(g_depth);

    t_wrf_word  mem [g_depth];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        full;

    assign count = wr_ptr - rd_ptr;
    assign empty = count == '0;
    assign full  = count == (AW + 1)'(g_depth);
    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_sys or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    // The sink's stall margin must make this unreachable.
    a_no_overflow: assert property (@(posedge clk_sys) disable iff (rst_n) !(push && full));

endmodule

// File: rtl/wrf_rx_sink.sv
// wrf_rx_sink: WR fabric sink turning Wishbone frames into a sop/eop framed valid/ready word stream.
// Define WRF_SINK_OOB_EN to forward OOB words (adr=1) in-band with out_oob_o set.
module wrf_rx_sink
    import wrf_sink_pkg::*;
#(
    parameter int g_fifo_depth = 64,
    parameter int g_cnt_width  = 32
) (
    input  logic                   clk_sys,
    input  logic                   rst_n,
    wrf_rx_sink_if.slave           snk,
    output logic [15:0]            out_dat_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic                   out_sop_o,
    output logic                   out_eop_o,
    output logic                   out_bytesel_o,
    output logic                   out_err_o,
    output logic                   out_oob_o,
    output logic [g_cnt_width-1:0] rx_frames_o,
    output logic [g_cnt_width-1:0] rx_err_frames_o
);

    localparam int AW = $clog2(g_fifo_depth);
    localparam logic [AW:0] c_stall_lvl = (AW + 1)'(g_fifo_depth - 2);

    t_sink_state            state, state_nxt;
    t_wrf_word              hold, hold_nxt, fifo_din, fifo_dout;
    logic                   hold_vld, hold_vld_nxt;
    logic                   first, first_nxt;
    logic                   err_flag, err_flag_nxt;
    logic                   push, empty;
    logic [AW:0]            count;
    logic                   accept, cut, set_err, is_word, is_oob;
    logic [g_cnt_width-1:0] frames_nxt, err_frames_nxt;
    logic                   unused_we;

    assign unused_we = snk.we;
    assign accept    = snk.cyc & snk.stb & ~snk.stall;
    assign cut       = accept & (snk.adr == c_WRF_DATA) & (snk.sel == 2'b00);
    assign set_err   = accept & (snk.adr == c_WRF_STATUS) & snk.dat[c_WRF_STATUS_ERR];

`ifdef WRF_SINK_OOB_EN
    assign is_oob  = snk.adr == c_WRF_OOB;
    assign is_word = accept & ~cut & ((snk.adr == c_WRF_DATA) | is_oob);
`else
    assign is_oob  = 1'b0;
    assign is_word = accept & ~cut & (snk.adr == c_WRF_DATA);
`endif

    // The last word of a frame stays in the holding register until cyc falls, so eop can be attached.
    always_comb begin
        state_nxt      = state;
        first_nxt      = first;
        err_flag_nxt   = err_flag;
        hold_nxt       = hold;
        hold_vld_nxt   = hold_vld;
        push           = 1'b0;
        fifo_din       = hold;
        fifo_din.eop   = 1'b0;
        fifo_din.bytesel = 1'b0;
        fifo_din.err   = 1'b0;
        frames_nxt     = rx_frames_o;
        err_frames_nxt = rx_err_frames_o;
        if (state == IDLE && snk.cyc) begin
            state_nxt    = FRAME;
            first_nxt    = 1'b1;
            err_flag_nxt = 1'b0;
        end else if (state == FRAME && !snk.cyc) begin
            state_nxt = IDLE;
            if (hold_vld) begin
                push             = 1'b1;
                fifo_din.eop     = 1'b1;
                fifo_din.bytesel = hold.bytesel;
                fifo_din.err     = err_flag;
                hold_vld_nxt     = 1'b0;
                frames_nxt       = rx_frames_o + 1'b1;
                err_frames_nxt   = err_flag ? rx_err_frames_o + 1'b1 : rx_err_frames_o;
            end
        end
        if (is_word) begin
            push         = hold_vld;
            hold_nxt     = '{dat: snk.dat, sop: first_nxt, eop: 1'b0,
                             bytesel: snk.sel == 2'b10, err: 1'b0, oob: is_oob};
            hold_vld_nxt = 1'b1;
            first_nxt    = 1'b0;
        end
        if (cut || set_err)
            err_flag_nxt = 1'b1;
    end

    always_ff @(posedge clk_sys or posedge rst_n) begin
        if (rst_n) begin
            state           <= IDLE;
            hold            <= '0;
            hold_vld        <= 1'b0;
            first           <= 1'b0;
            err_flag        <= 1'b0;
            rx_frames_o     <= '0;
            rx_err_frames_o <= '0;
            snk.stall       <= 1'b0;
            snk.ack         <= 1'b0;
            snk.err         <= 1'b0;
        end else begin
            state           <= state_nxt;
            hold            <= hold_nxt;
            hold_vld        <= hold_vld_nxt;
            first           <= first_nxt;
            err_flag        <= err_flag_nxt;
            rx_frames_o     <= frames_nxt;
            rx_err_frames_o <= err_frames_nxt;
            snk.stall       <= count >= c_stall_lvl;
            snk.ack         <= accept & ~cut;
            snk.err         <= cut;
        end
    end

    wrf_sink_fifo #(.g_depth(g_fifo_depth)) u_fifo (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (out_ready_i),
        .din     (fifo_din),
        .dout    (fifo_dout),
        .empty   (empty),
        .count   (count)
    );

    assign out_valid_o   = ~empty;
    assign out_dat_o     = fifo_dout.dat;
    assign out_sop_o     = fifo_dout.sop;
    assign out_eop_o     = fifo_dout.eop;
    assign out_bytesel_o = fifo_dout.bytesel;
    assign out_err_o     = fifo_dout.err;
    assign out_oob_o     = fifo_dout.oob;

endmodule

// File: tb/tb_wrf_rx_sink.sv
// tb_wrf_rx_sink: directed frames against wrf_rx_sink; expected stream words are queued at issue time
// and a negedge monitor pops and compares them, alongside ack/err response checks.
`timescale 1ns/1ps
module tb_wrf_rx_sink;
    import wrf_sink_pkg::*;

    typedef struct {
        logic [1:0]  adr;
        logic [15:0] dat;
        logic [1:0]  sel;
    } item_t;

    logic        clk_sys = 1'b0;
    logic        rst_n   = 1'b1;
    logic [15:0] out_dat;
    logic        out_valid, out_ready, out_sop, out_eop, out_bytesel, out_err, out_oob;
    logic [31:0] rx_frames, rx_err_frames;

    int        vectors = 0;
    int        miscompares = 0;
    int        n_acc = 0;
    int        n_ack = 0;
    bit        exp_ack = 0;
    bit        exp_err = 0;
    t_wrf_word exp_q[$];
    t_wrf_word w;
    item_t     fr[$];

    always #5 clk_sys = ~clk_sys;

    wrf_rx_sink_if snk();

    wrf_rx_sink dut (
        .clk_sys         (clk_sys),
        .rst_n           (rst_n),
        .snk             (snk),
        .out_dat_o       (out_dat),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .out_sop_o       (out_sop),
        .out_eop_o       (out_eop),
        .out_bytesel_o   (out_bytesel),
        .out_err_o       (out_err),
        .out_oob_o       (out_oob),
        .rx_frames_o     (rx_frames),
        .rx_err_frames_o (rx_err_frames)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Response and stream monitor, sampled away from the active edge.
    always @(negedge clk_sys) begin
        if (rst_n) begin
            exp_ack = 0;
            exp_err = 0;
        end else begin
            check("ack", snk.ack, exp_ack);
            check("err_resp", snk.err, exp_err);
            if (snk.ack === 1'b1)
                n_ack++;
            exp_ack = snk.cyc && snk.stb && !snk.stall && !(snk.adr == 2'd0 && snk.sel == 2'b00);
            exp_err = snk.cyc && snk.stb && !snk.stall && (snk.adr == 2'd0 && snk.sel == 2'b00);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL stream: unexpected word %h", {out_dat, out_sop, out_eop, out_bytesel, out_err, out_oob});
                end else begin
                    w = exp_q.pop_front();
                    check("stream_word", {11'd0, out_dat, out_sop, out_eop, out_bytesel, out_err, out_oob}, {11'd0, w});
                end
            end
        end
    end

    task automatic wr(input logic [1:0] adr, input logic [15:0] dat, input logic [1:0] sel);
        int t = 0;
        bit acc = 0;
        snk.cyc = 1; snk.stb = 1; snk.we = 1;
        snk.adr = adr; snk.dat = dat; snk.sel = sel;
        do begin
            @(negedge clk_sys);
            acc = !snk.stall;
            @(posedge clk_sys);
            #1;
            t++;
        end while (!acc && t < 400);
        snk.stb = 0;
        if (acc)
            n_acc++;
        else begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: adr %0d dat %h not accepted in %0d cycles", adr, dat, t);
        end
    endtask

    task automatic add(input logic [1:0] adr, input logic [15:0] dat, input logic [1:0] sel);
        item_t it;
        it.adr = adr; it.dat = dat; it.sel = sel;
        fr.push_back(it);
    endtask

    // Queues the expected words of fr (when model=1), then drives it as one cyc frame.
    task automatic send_frame(input bit model);
        t_wrf_word  last = '0;
        bit         have = 0, first = 1, err = 0, word;
        logic [1:0] tail_sel = 2'b11;
        if (model) begin
            foreach (fr[i]) begin
`ifdef WRF_SINK_OOB_EN
                word = (fr[i].adr == 2'd0 && fr[i].sel != 2'b00) || fr[i].adr == 2'd1;
`else
                word = fr[i].adr == 2'd0 && fr[i].sel != 2'b00;
`endif
                if (fr[i].adr == 2'd2 && fr[i].dat[1]) err = 1;
                if (fr[i].adr == 2'd0 && fr[i].sel == 2'b00) err = 1;
                if (word) begin
                    if (have) exp_q.push_back(last);
                    last = '{dat: fr[i].dat, sop: first, eop: 1'b0, bytesel: 1'b0, err: 1'b0, oob: fr[i].adr == 2'd1};
                    tail_sel = fr[i].sel;
                    first = 0;
                    have = 1;
                end
            end
            if (have) begin
                last.eop = 1'b1;
                last.bytesel = tail_sel == 2'b10;
                last.err = err;
                exp_q.push_back(last);
            end
        end
        foreach (fr[i]) wr(fr[i].adr, fr[i].dat, fr[i].sel);
        snk.cyc = 0;
        repeat (3) @(posedge clk_sys);
        #1;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() > 0 && t < 3000) begin
            @(posedge clk_sys);
            t++;
        end
        check(name, exp_q.size(), 0);
        repeat (2) @(posedge clk_sys);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack0, base;
        snk.cyc = 0; snk.stb = 0; snk.we = 0; snk.adr = 0; snk.dat = 0; snk.sel = 0;
        out_ready = 1;
        repeat (3) @(posedge clk_sys);
        #1 rst_n = 0;
        @(negedge clk_sys);
        check("reset_valid", out_valid, 0);
        check("reset_dat", out_dat, 0);
        check("reset_stall", snk.stall, 0);
        check("reset_frames", rx_frames, 0);
        check("reset_err_frames", rx_err_frames, 0);
        @(posedge clk_sys);
        #1;

        // 60-byte frame
        ack0 = n_ack;
        fr.delete();
        for (int i = 0; i < 30; i++) add(2'd0, 16'(i), 2'b11);
        send_frame(1);
        drain("t1_drain");
        check("t1_acks", n_ack - ack0, 30);
        check("t1_frames", rx_frames, 1);
        check("t1_err_frames", rx_err_frames, 0);

        // 61-byte frame with error status
        fr.delete();
        for (int i = 0; i < 30; i++) add(2'd0, 16'h1000 + 16'(i), 2'b11);
        add(2'd0, 16'h3D00, 2'b10);
        add(2'd2, 16'h0002, 2'b11);
        send_frame(1);
        drain("t2_drain");
        check("t2_frames", rx_frames, 2);
        check("t2_err_frames", rx_err_frames, 1);

        // Backpressure: 100 words into a 64-deep FIFO
        out_ready = 0;
        base = n_acc;
        fr.delete();
        for (int i = 0; i < 100; i++) add(2'd0, 16'h0100 + 16'(i), 2'b11);
        fork
            send_frame(1);
            begin
                int t = 0;
                while (snk.stall !== 1'b1 && t < 500) begin
                    @(negedge clk_sys);
                    t++;
                end
                check("t3_stall", snk.stall, 1);
                check("t3_accepts_at_stall", n_acc - base, 64);
                repeat (20) @(negedge clk_sys);
                check("t3_accepts_held", n_acc - base, 64);
                check("t3_valid_blocked", out_valid, 1);
                check("t3_head_stable", out_dat, 16'h0100);
                @(posedge clk_sys);
                #1 out_ready = 1;
            end
        join
        drain("t3_drain");
        check("t3_frames", rx_frames, 3);

        // Zero-length frame
        ack0 = n_ack;
        fr.delete();
        add(2'd2, 16'h0000, 2'b11);
        send_frame(1);
        drain("t4_drain");
        check("t4_acks", n_ack - ack0, 1);
        check("t4_valid", out_valid, 0);
        check("t4_frames", rx_frames, 3);
        check("t4_err_frames", rx_err_frames, 1);

        // Malformed data word cuts the frame into error
        fr.delete();
        add(2'd0, 16'h00A0, 2'b11);
        add(2'd0, 16'h00A1, 2'b11);
        add(2'd0, 16'hDEAD, 2'b00);
        add(2'd0, 16'h00A2, 2'b11);
        add(2'd3, 16'h5555, 2'b11);
        send_frame(1);
        drain("t5_drain");
        check("t5_frames", rx_frames, 4);
        check("t5_err_frames", rx_err_frames, 2);

        // Reset in the middle of a frame
        out_ready = 0;
        for (int i = 0; i < 10; i++) wr(2'd0, 16'h0700 + 16'(i), 2'b11);
        rst_n = 1;
        snk.cyc = 0;
        snk.stb = 0;
        repeat (2) @(posedge clk_sys);
        #1 rst_n = 0;
        @(negedge clk_sys);
        check("t6_valid", out_valid, 0);
        check("t6_frames", rx_frames, 0);
        check("t6_err_frames", rx_err_frames, 0);
        @(posedge clk_sys);
        #1 out_ready = 1;
        fr.delete();
        for (int i = 0; i < 20; i++) add(2'd0, 16'h0800 + 16'(i), 2'b11);
        send_frame(1);
        drain("t6_drain");
        check("t6_frames_after", rx_frames, 1);

        // OOB trailer
        fr.delete();
        for (int i = 0; i < 30; i++) add(2'd0, 16'h0200 + 16'(i), 2'b11);
        for (int i = 0; i < 3; i++) add(2'd1, 16'h0F00 + 16'(i), 2'b11);
        send_frame(1);
        drain("t7_drain");
        check("t7_frames", rx_frames, 2);
        check("t7_err_frames", rx_err_frames, 0);

        repeat (3) @(posedge clk_sys);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
